bs_mult_ctrl: RTL and testbench
===============================

// Module: bs_mult_ctrl
// PURPOSE
//  Sequencer for one bit-serial multiplier slice array (WIDTH slices).
//  - Accepts a WIDTH x WIDTH operand pair on a valid/ready handshake.
//  - Streams both operands LSB-first into the array and drives its rin token and lastbit clear.
//  - Deserialises the 2*WIDTH-bit serial product and presents it on a valid/ready result port.
//  - Sits between the accumulator front-end and the bs_mult slice chain.
// PARAMETERS
//  WIDTH     8  operand width in bits; the product is 2*WIDTH bits.
//  PIPE_DLY  1  cycles from injecting serial bit k to product bit k appearing on p_ser (>=1).
// PORTS
//  clk        in   1         clock; all logic is on the rising edge.
//  rst        in   1         synchronous reset, active-high.
//  op_valid   in   1         operand pair valid.
//  op_ready   out  1         block can accept operands (IDLE only).
//  op_x       in   WIDTH     multiplicand.
//  op_y       in   WIDTH     multiplier.
//  x_ser      out  1         serial x bit to the array (LSB first).
//  y_ser      out  1         serial y bit to the array (LSB first).
//  rin_ser    out  1         token marking serial bit 0; drives rin of the first slice.
//  lastbit    out  1         clears the array's internal delay/carry registers.
//  p_ser      in   1         serial product bit from the array.
//  res_valid  out  1         product available.
//  res_ready  in   1         consumer takes the product.
//  res_p      out  2*WIDTH   product.
//  busy       out  1         high in any state other than IDLE.
// BEHAVIOUR
//  States: CLEAR, IDLE, RUN, DONE. Registers: state, cnt, xr, yr, pr.
//  Reset (rst=1 at an edge):
//   - state<=CLEAR, cnt<=0, xr/yr/pr<=0.
//   - While state=CLEAR: lastbit=1, op_ready=0, res_valid=0, x_ser=y_ser=rin_ser=0, res_p=0.
//  CLEAR: lasts exactly one cycle (lastbit=1), then IDLE.
//  IDLE:
//   - op_ready=1.
//   - On op_valid&&op_ready: xr<=op_x, yr<=op_y, pr<=0, cnt<=0, go to RUN.
//  RUN: cnt runs 0 .. 2*WIDTH+PIPE_DLY-1.
//   - x_ser = (cnt<WIDTH) ? xr[cnt] : 0.
//   - y_ser = (cnt<WIDTH) ? yr[cnt] : 0.
//   - rin_ser = (cnt==0).
//   - When cnt>=PIPE_DLY: pr <= {p_ser, pr[2W-1:1]}. There are exactly 2*WIDTH captures, so product bit k lands in pr[k].
//   - At cnt==2*WIDTH+PIPE_DLY-1: go to CLEAR-then-DONE. Implement this as an internal flag; lastbit=1 for one cycle, then DONE.
//  DONE:
//   - res_valid=1; res_p=pr, held stable until accepted.
//   - On res_ready: go to IDLE.
//   - No accept-and-load in the same cycle: op_ready=0 in DONE.
//  Outputs are combinational decodes of registered state only (no input-to-output paths).
//  Latency: handshake at edge T -> res_valid high in cycle T+2*WIDTH+PIPE_DLY+2 (W=8, D=1: 19).
//   - With res_ready held high, throughput is one product per 2*WIDTH+PIPE_DLY+3 cycles.
//  Operand ports are ignored outside IDLE; changes to op_x/op_y during RUN have no effect.
//  Reset mid-operation:
//   - Any state returns to CLEAR; the partial product is discarded.
//   - res_valid is not asserted for the aborted operation.
//  op_valid with op_ready=0 is not an error; the operand simply waits.
//  Width rule: the result is the full unsigned product, no truncation.
//   - 2*WIDTH serial bits are injected (upper WIDTH are zero) so carries fully propagate.
// TESTING (bench uses a cycle model of the slice array with PIPE_DLY=1; WIDTH=8)
//  1 Reset then 0xFF*0xFF with res_ready=1.
//    -> lastbit=1 in the 1st post-reset cycle; res_p=0xFE01.
//    -> res_valid exactly 19 cycles after the accept edge.
//  2 0x00*0xA5 and 0x01*0x80 -> res_p=0x0000, then 0x0080; rin_ser pulses once per op.
//  3 0x12*0x34 with res_ready=0 for 5 cycles -> res_p=0x03A8 stable; res_valid=1; op_ready=0 throughout.
//  4 Assert rst at RUN cnt=5 for 1 cycle -> next cycle lastbit=1, then op_ready=1; no res_valid.
//    -> A following 0x03*0x05 gives 0x000F.
//  5 Back-to-back op_valid held high with 3*5, 200*100, 0x80*0x02 -> 0x000F, 0x4E20, 0x0100 in order.
//  6 Toggle op_x/op_y/op_valid every cycle during RUN of 0x0F*0x0F -> res_p=0x00E1; no extra accepts.

Source files
------------

// File: rtl/bs_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bs_mult_ctrl
//  Description : Sequencer for a bit-serial multiplier slice array. It streams
//                operands LSB-first and deserialises the serial product.
//  Revision    : 1.0  initial release
// ============================================================================
module bs_mult_ctrl #(
    parameter int WIDTH    = 8,
    parameter int PIPE_DLY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [WIDTH-1:0]     op_x,
    input  logic [WIDTH-1:0]     op_y,
    output logic                 x_ser,
    output logic                 y_ser,
    output logic                 rin_ser,
    output logic                 lastbit,
    input  logic                 p_ser,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*WIDTH-1:0]   res_p,
    output logic                 busy
);

    localparam int CW = $clog2(2*WIDTH + PIPE_DLY);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] c_CNT_LAST = CW'(2*WIDTH + PIPE_DLY - 1);
    localparam logic [CW-1:0] c_CNT_W    = CW'(WIDTH);
    localparam logic [CW-1:0] c_CNT_DLY  = CW'(PIPE_DLY);

    localparam logic [1:0] c_ST_CLEAR = 2'd0;
    localparam logic [1:0] c_ST_IDLE  = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_xr;
    logic [WIDTH-1:0]   r_yr;
    logic [2*WIDTH-1:0] r_pr;
    // Set when CLEAR is entered from RUN, so CLEAR exits to DONE instead of IDLE.
    logic               r_fin;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_CLEAR;
            r_cnt   <= '0;
            r_xr    <= '0;
            r_yr    <= '0;
            r_pr    <= '0;
            r_fin   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_CLEAR: begin
                    r_state <= r_fin ? c_ST_DONE : c_ST_IDLE;
                    r_fin   <= 1'b0;
                end
                c_ST_IDLE: begin
                    if (op_valid) begin
                        r_xr    <= op_x;
                        r_yr    <= op_y;
                        r_pr    <= '0;
                        r_cnt   <= '0;
                        r_state <= c_ST_RUN;
                    end
                end
                c_ST_RUN: begin
                    // Product bit k arrives PIPE_DLY cycles after input bit k.
                    if (r_cnt >= c_CNT_DLY) begin
                        r_pr <= {p_ser, r_pr[2*WIDTH-1:1]};
                    end
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_fin   <= 1'b1;
                        r_state <= c_ST_CLEAR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_DONE: begin
                    if (res_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_CLEAR;
            endcase
        end
    end

    logic w_run;
    logic w_in_op;

    assign w_run   = (r_state == c_ST_RUN);
    assign w_in_op = (r_cnt < c_CNT_W);

    assign x_ser     = w_run && w_in_op && r_xr[r_cnt[IW-1:0]];
    assign y_ser     = w_run && w_in_op && r_yr[r_cnt[IW-1:0]];
    assign rin_ser   = w_run && (r_cnt == '0);
    assign lastbit   = (r_state == c_ST_CLEAR);
    assign op_ready  = (r_state == c_ST_IDLE);
    assign res_valid = (r_state == c_ST_DONE);
    assign res_p     = res_valid ? r_pr : '0;
    assign busy      = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bs_mult_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bs_mult_ctrl
//  Description : Directed scoreboard bench for bs_mult_ctrl with a serial
//                multiplier array model (one cycle from input bit to product bit).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bs_mult_ctrl;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           op_valid = 1'b0;
    logic           op_ready;
    logic [W-1:0]   op_x = '0;
    logic [W-1:0]   op_y = '0;
    logic           x_ser;
    logic           y_ser;
    logic           rin_ser;
    logic           lastbit;
    logic           p_ser;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic [2*W-1:0] res_p;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int rin_cnt  = 0;
    int acc_cnt  = 0;
    logic [2*W-1:0] sb[$];

    bs_mult_ctrl #(.WIDTH(W), .PIPE_DLY(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_x      (op_x),
        .op_y      (op_y),
        .x_ser     (x_ser),
        .y_ser     (y_ser),
        .rin_ser   (rin_ser),
        .lastbit   (lastbit),
        .p_ser     (p_ser),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Array model: gathers serial bits since the rin token and returns product bit k.
    logic [31:0] m_x;
    logic [31:0] m_y;
    logic [4:0]  m_k;
    logic [31:0] w_nx;
    logic [31:0] w_ny;
    logic [4:0]  w_nk;
    logic [63:0] w_prod;

    always_comb begin
        w_nk = rin_ser ? 5'd0 : ((m_k == 5'd31) ? 5'd31 : m_k + 5'd1);
        w_nx = rin_ser ? 32'd0 : m_x;
        w_ny = rin_ser ? 32'd0 : m_y;
        w_nx[w_nk] = x_ser;
        w_ny[w_nk] = y_ser;
        w_prod = {32'd0, w_nx} * {32'd0, w_ny};
    end

    always @(posedge clk) begin
        m_x   <= w_nx;
        m_y   <= w_ny;
        m_k   <= w_nk;
        p_ser <= w_prod[w_nk];
        if (rin_ser) rin_cnt <= rin_cnt + 1;
        if (!rst && op_valid && op_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called and returns at a falling edge.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit keep_valid,
                         input int stall, input bit toggle, input bit chk_lat);
        int n;
        int r0;
        logic [2*W-1:0] held;
        logic [2*W-1:0] exp;
        op_x      = x;
        op_y      = y;
        op_valid  = 1'b1;
        res_ready = (stall == 0);
        n = 0;
        while (!op_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(op_ready), 32'd1);
        sb.push_back(16'(x) * 16'(y));
        r0 = rin_cnt;
        @(negedge clk);
        op_valid = keep_valid;
        n = 1;
        while (!res_valid && n < 60) begin
            if (toggle) begin
                op_x     = 8'($urandom);
                op_y     = 8'($urandom);
                op_valid = ~op_valid;
            end
            @(negedge clk);
            n++;
        end
        if (toggle) op_valid = 1'b0;
        check("res_valid_seen", 32'(res_valid), 32'd1);
        if (chk_lat) check("latency", n, 32'd19);
        check("rin_pulses", rin_cnt - r0, 32'd1);
        exp  = sb.pop_front();
        held = res_p;
        check("res_p", 32'(res_p), 32'(exp));
        repeat (stall) begin
            @(negedge clk);
            check("stall_valid", 32'(res_valid), 32'd1);
            check("stall_res_p", 32'(res_p), 32'(held));
            check("stall_op_ready", 32'(op_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        check("done_released", 32'(res_valid), 32'd0);
    endtask

    initial begin
        int a0;
        int rv;

        // Reset and the CLEAR cycle that follows it
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("clr_lastbit", 32'(lastbit), 32'd1);
        check("clr_op_ready", 32'(op_ready), 32'd0);
        check("clr_res_valid", 32'(res_valid), 32'd0);
        check("clr_res_p", 32'(res_p), 32'd0);
        check("clr_serial", {29'd0, x_ser, y_ser, rin_ser}, 32'd0);
        check("clr_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("idle_op_ready", 32'(op_ready), 32'd1);
        check("idle_lastbit", 32'(lastbit), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // Full-scale operands with latency measurement
        do_op(8'hFF, 8'hFF, 1'b0, 0, 1'b0, 1'b1);

        // Zero operand and single-bit operand
        do_op(8'h00, 8'hA5, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'h01, 8'h80, 1'b0, 0, 1'b0, 1'b0);

        // Consumer back-pressure
        do_op(8'h12, 8'h34, 1'b0, 5, 1'b0, 1'b0);

        // Reset mid-operation at cnt=5
        op_x = 8'h03;
        op_y = 8'h07;
        op_valid = 1'b1;
        @(negedge clk);
        op_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_lastbit", 32'(lastbit), 32'd1);
        check("abort_op_ready", 32'(op_ready), 32'd0);
        @(negedge clk);
        check("abort_idle_ready", 32'(op_ready), 32'd1);
        rv = 0;
        repeat (25) begin
            if (res_valid) rv++;
            @(negedge clk);
        end
        check("abort_no_res_valid", rv, 32'd0);
        do_op(8'h03, 8'h05, 1'b0, 0, 1'b0, 1'b0);

        // Back-to-back with op_valid held high
        a0 = acc_cnt;
        do_op(8'd3, 8'd5, 1'b1, 0, 1'b0, 1'b0);
        do_op(8'd200, 8'd100, 1'b1, 0, 1'b0, 1'b0);
        do_op(8'h80, 8'h02, 1'b0, 0, 1'b0, 1'b0);
        check("b2b_accepts", acc_cnt - a0, 32'd3);

        // Operand port activity during RUN must be ignored
        a0 = acc_cnt;
        do_op(8'h0F, 8'h0F, 1'b0, 0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("toggle_accepts", acc_cnt - a0, 32'd1);
        check("toggle_idle", 32'(busy), 32'd0);

        check("scoreboard_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
